// File: rtl/user_tree_pkg.sv
// Message-tree constants and tables shared by the path-lookup controller,
// its path stack and the handshake interface.
package user_tree_pkg;

  localparam int NUM_MSG_HIERARCHY = 2;
  localparam int NUM_MSGS          = 2;
  localparam int IDENTIFIER_SIZE   = 8;
  localparam int DEPTH_W           = $clog2(NUM_MSG_HIERARCHY + 1);
  localparam int IDX_W             = $clog2(NUM_MSGS);

  typedef logic [IDENTIFIER_SIZE-1:0] identifier;
  // Element [0] is the outermost level of the path.
  typedef identifier [NUM_MSG_HIERARCHY-1:0] dependency;
  typedef dependency dependencies_t [NUM_MSGS];
  typedef logic [7:0] node_data;

  typedef enum logic {OP_PUSH, OP_POP} tree_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} lookup_state_t;

  localparam node_data NODE_PERSON       = 8'd0;
  localparam node_data NODE_PHONE_NUMBER = 8'd1;

  // AA/00 -> Person, AA/BB -> PhoneNumber
  localparam dependencies_t dependencies = '{
    '{8'h00, 8'hAA},
    '{8'hBB, 8'hAA}
  };

  localparam node_data node_ROM [NUM_MSGS] = '{NODE_PERSON, NODE_PHONE_NUMBER};

endpackage

// File: rtl/tree_path_lookup_ctrl_if.sv
// Command/response handshake bundle between the identifier decoder, the
// path-lookup controller and the downstream node handlers.
interface tree_path_lookup_ctrl_if;
  import user_tree_pkg::*;

  logic             in_valid;
  logic             in_ready;
  tree_op_t         in_op;
  identifier        in_id;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  node_data         out_node;
  logic [IDX_W-1:0] out_idx;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_op, in_id, out_ready,
    output in_ready, out_valid, out_hit, out_node, out_idx, out_ovf
  );

  modport master (
    output in_valid, in_op, in_id, out_ready,
    input  in_ready, out_valid, out_hit, out_node, out_idx, out_ovf
  );

endinterface

// File: rtl/tree_path_stack.sv
// Identifier stack holding the current message path; exposes the path as a
// dependency vector with unused levels forced to zero.
module tree_path_stack
  import user_tree_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  identifier          i_id,
  output logic [DEPTH_W-1:0] o_depth,
  output dependency          o_path,
  output logic               o_ovf,
  output logic               o_udf
);

  identifier          r_stack [NUM_MSG_HIERARCHY];
  logic [DEPTH_W-1:0] r_depth;

  assign o_depth = r_depth;
  assign o_ovf   = i_push & (r_depth == DEPTH_W'(NUM_MSG_HIERARCHY));
  assign o_udf   = i_pop & (r_depth == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++) r_stack[i] <= '0;
    end else if (i_push && !o_ovf) begin
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
        if (DEPTH_W'(i) == r_depth) r_stack[i] <= i_id;
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (i_pop && !o_udf) begin
      // Vacated level is cleared so stale identifiers never reach the path.
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
        if (DEPTH_W'(i) == r_depth - DEPTH_W'(1)) r_stack[i] <= '0;
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  always_comb begin
    o_path = '0;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
      if (DEPTH_W'(i) < r_depth) o_path[i] = r_stack[i];
  end

endmodule

// File: rtl/tree_path_lookup_ctrl.sv
// Message-tree path lookup controller: PUSH scans the dependencies table in
// index order and returns node_ROM data. Optional: TREE_LOOKUP_ERR_CNT_EN.
//
// state   | meaning
// IDLE    | accepting PUSH/POP commands
// SCAN    | comparing path against dependencies[r_idx], one entry per cycle
// RESP    | result presented, held until out_ready
module tree_path_lookup_ctrl
  import user_tree_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  tree_path_lookup_ctrl_if.slave bus,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  err_pulse
`ifdef TREE_LOOKUP_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_SCAN = ST_SCAN;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_hit;
  node_data         r_node;
  logic             r_ovf;
  logic             r_err_pulse;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf;
  logic               w_udf;
  logic               w_match;
  logic               w_last;
  logic               w_err_evt;
  logic [DEPTH_W-1:0] w_depth;
  dependency          w_path;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_push    = w_accept && (bus.in_op == OP_PUSH);
  assign w_pop     = w_accept && (bus.in_op == OP_POP);
  assign w_match   = (r_state == S_SCAN) && (w_path == dependencies[r_idx]);
  assign w_last    = (r_idx == IDX_W'(NUM_MSGS - 1));
  assign w_err_evt = (w_push && w_ovf) || (w_pop && w_udf);

  tree_path_stack u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_id    (bus.in_id),
    .o_depth (w_depth),
    .o_path  (w_path),
    .o_ovf   (w_ovf),
    .o_udf   (w_udf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_node      <= '0;
      r_ovf       <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err_evt;
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_idx  <= '0;
            r_hit  <= 1'b0;
            r_node <= '0;
            r_ovf  <= w_ovf;
            r_state <= w_ovf ? S_RESP : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_hit   <= 1'b1;
            r_node  <= node_ROM[r_idx];
            r_state <= S_RESP;
          end else if (w_last) begin
            r_hit   <= 1'b0;
            r_node  <= '0;
            r_idx   <= '0;
            r_state <= S_RESP;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_RESP: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_RESP);
  assign bus.out_hit   = r_hit;
  assign bus.out_node  = r_node;
  assign bus.out_idx   = r_idx;
  assign bus.out_ovf   = r_ovf;
  assign depth         = w_depth;
  assign err_pulse     = r_err_pulse;

`ifdef TREE_LOOKUP_ERR_CNT_EN
  logic       w_miss;
  logic [7:0] r_err_cnt;

  assign w_miss = (r_state == S_SCAN) && !w_match && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_cnt <= '0;
    else if ((w_err_evt || w_miss) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tree_path_lookup_ctrl.sv
// Directed table-driven bench for tree_path_lookup_ctrl plus hand-written
// back-pressure and mid-scan reset sequences.
module tb_tree_path_lookup_ctrl;
  import user_tree_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DEPTH_W-1:0] depth;
  logic err_pulse;
`ifdef TREE_LOOKUP_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  tree_path_lookup_ctrl_if bus_if ();

  tree_path_lookup_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .depth     (depth),
    .err_pulse (err_pulse)
`ifdef TREE_LOOKUP_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;      // 0=PUSH 1=POP
    logic [7:0] id;
    int         lat;     // cycles from accept to out_valid (PUSH only)
    logic       hit;
    int         idx;
    int         node;
    logic       ovf;
    int         dep;     // depth when checked
    logic       err;     // err_pulse at T+1
  } vec_t;

  int total = 0;
  int bad   = 0;
  int model_err_cnt = 0;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [7:0] id);
    int guard = 0;
    @(negedge clk);
    while (!bus_if.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_cmd", int'(bus_if.in_ready), 1);
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = tree_op_t'(op);
    bus_if.in_id    = id;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Returns the latency at which out_valid was seen (cycle after accept = 1).
  task automatic wait_resp(output int lat, output logic err_t1);
    lat = 1;
    err_t1 = err_pulse;
    while (!bus_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_cmd(input vec_t v, input int n);
    int lat;
    logic err_t1;
    issue(v.op, v.id);
    if (v.op == 1'b0) begin
      wait_resp(lat, err_t1);
      chk($sformatf("v%0d_latency", n), lat, v.lat);
      chk($sformatf("v%0d_err_pulse", n), int'(err_t1), int'(v.err));
      chk($sformatf("v%0d_hit", n), int'(bus_if.out_hit), int'(v.hit));
      chk($sformatf("v%0d_idx", n), int'(bus_if.out_idx), v.idx);
      chk($sformatf("v%0d_node", n), int'(bus_if.out_node), v.node);
      chk($sformatf("v%0d_ovf", n), int'(bus_if.out_ovf), int'(v.ovf));
      chk($sformatf("v%0d_depth", n), int'(depth), v.dep);
      if (!v.hit && !v.ovf) model_err_cnt++;
    end else begin
      chk($sformatf("v%0d_err_pulse", n), int'(err_pulse), int'(v.err));
      chk($sformatf("v%0d_depth", n), int'(depth), v.dep);
      chk($sformatf("v%0d_no_valid", n), int'(bus_if.out_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_no_valid_late", n), int'(bus_if.out_valid), 0);
      chk($sformatf("v%0d_err_one_cycle", n), int'(err_pulse), 0);
    end
    if (v.err) model_err_cnt++;
  endtask

  initial begin
    int lat;
    logic err_t1;

    bus_if.in_valid  = 1'b0;
    bus_if.in_op     = OP_PUSH;
    bus_if.in_id     = 8'h00;
    bus_if.out_ready = 1'b1;

    //          op    id     lat hit idx node ovf dep err
    vecs[0] = '{1'b0, 8'hAA, 2, 1'b1, 0, 0, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b0, 8'hBB, 3, 1'b1, 1, 1, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b0, 8'hCC, 1, 1'b0, 0, 0, 1'b1, 2, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 1, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 0, 1'b1};
    vecs[6] = '{1'b0, 8'hAA, 2, 1'b1, 0, 0, 1'b0, 1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 2, 1'b1, 0, 0, 1'b0, 2, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 1, 1'b0};
    vecs[9] = '{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus_if.in_ready), 1);
    chk("rst_out_valid", int'(bus_if.out_valid), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_out_hit", int'(bus_if.out_hit), 0);
    chk("rst_out_ovf", int'(bus_if.out_ovf), 0);
`ifdef TREE_LOOKUP_ERR_CNT_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_cmd(vecs[i], i);

    // Miss with back-pressure: path BB/00 matches no entry.
    bus_if.out_ready = 1'b0;
    issue(1'b0, 8'hBB);
    wait_resp(lat, err_t1);
    model_err_cnt++;
    chk("miss_latency", lat, 3);
    chk("miss_err_pulse", int'(err_t1), 0);
    chk("miss_depth", int'(depth), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), int'(bus_if.out_valid), 1);
      chk($sformatf("hold%0d_hit", c), int'(bus_if.out_hit), 0);
      chk($sformatf("hold%0d_node", c), int'(bus_if.out_node), 0);
      chk($sformatf("hold%0d_idx", c), int'(bus_if.out_idx), 0);
      chk($sformatf("hold%0d_ovf", c), int'(bus_if.out_ovf), 0);
      chk($sformatf("hold%0d_in_ready", c), int'(bus_if.in_ready), 0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(bus_if.out_valid), 0);
    chk("release_in_ready", int'(bus_if.in_ready), 1);
`ifdef TREE_LOOKUP_ERR_CNT_EN
    chk("err_cnt_after_cases", int'(err_cnt), model_err_cnt);
    chk("err_cnt_is_three", int'(err_cnt), 3);
`endif

    // The miss left BB pushed; pop it before the reset scenario.
    do_cmd('{1'b1, 8'h00, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0}, 10);
    do_cmd('{1'b0, 8'hAA, 2, 1'b1, 0, 0, 1'b0, 1, 1'b0}, 11);

    // Reset while scanning for AA/BB.
    issue(1'b0, 8'hBB);
    chk("scan_in_ready", int'(bus_if.in_ready), 0);
    chk("scan_depth", int'(depth), 2);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", int'(bus_if.in_ready), 1);
    chk("abort_out_valid", int'(bus_if.out_valid), 0);
    chk("abort_depth", int'(depth), 0);
    @(negedge clk);
    chk("abort_out_valid_late", int'(bus_if.out_valid), 0);
`ifdef TREE_LOOKUP_ERR_CNT_EN
    chk("abort_err_cnt", int'(err_cnt), 0);
`endif
    rst = 1'b0;
    model_err_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_stale_valid", int'(bus_if.out_valid), 0);
    end
    do_cmd('{1'b0, 8'hAA, 2, 1'b1, 0, 0, 1'b0, 1, 1'b0}, 12);
    do_cmd('{1'b0, 8'hBB, 3, 1'b1, 1, 1, 1'b0, 2, 1'b0}, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
